// File: rtl/four_bit_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// four_bit_add_sub_pkg
// Shared constants for the registered adder/subtractor leaf.
//   DEFAULT_WIDTH : default operand/result width
//   OP_ADD/OP_SUB : encoding of the ctrl operation-select input
// -----------------------------------------------------------------------------
package four_bit_add_sub_pkg;

    localparam int   DEFAULT_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : four_bit_add_sub_pkg

// File: rtl/four_bit_add_sub_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// One-bit full adder, the repeated cell of the ripple-carry chain.
//   a, b, cin : input bits and carry-in
//   s         : sum bit  (a ^ b ^ cin)
//   cout      : carry-out (a & b | cin & (a ^ b))
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder_cell

// File: rtl/four_bit_add_sub.sv
// -----------------------------------------------------------------------------
// four_bit_add_sub
// Registered WIDTH-bit adder/subtractor built from a ripple chain of
// full_adder_cell instances. Subtraction is in1 + ~in2 + 1: ctrl both inverts
// in2 and feeds the carry-in of bit 0. Result and carry-out appear one clock
// after the operands are sampled.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears sum and crry
//   in1   : operand A
//   in2   : operand B
//   ctrl  : 0 = add (A + B), 1 = subtract (A - B)
//   sum   : registered result bits
//   crry  : registered carry-out of the MSB cell (for subtract, 1 = no borrow)
// There is no handshake or enable: a new result is captured on every edge.
// -----------------------------------------------------------------------------
module four_bit_add_sub
    import four_bit_add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ctrl,
    output logic [WIDTH-1:0] sum,
    output logic             crry
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;
    logic             is_sub;

    assign is_sub   = (ctrl == OP_SUB);

    // Conditional inversion stage: ones' complement of in2 when subtracting.
    assign b_eff    = in2 ^ {WIDTH{is_sub}};

    // The +1 of the two's complement enters as the chain carry-in.
    assign carry[0] = is_sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_fa (
            .a    (in1[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            crry <= 1'b0;
        end else begin
            sum  <= s;
            crry <= carry[WIDTH];
        end
    end

endmodule : four_bit_add_sub

// File: tb/tb_four_bit_add_sub.sv
// -----------------------------------------------------------------------------
// tb_four_bit_add_sub
// Self-checking bench for four_bit_add_sub (WIDTH = 4). Each driven operand set
// pushes its expected {crry,sum} onto exp_q; a monitor pops and compares one
// entry shortly after every rising edge while out of reset.
// -----------------------------------------------------------------------------
module tb_four_bit_add_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         ctrl;
    logic [W-1:0] sum;
    logic         crry;

    logic [W:0]   exp_q[$];
    int           n_vec;
    int           n_miss;

    four_bit_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .ctrl  (ctrl),
        .sum   (sum),
        .crry  (crry)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got crry/sum=%b/%b, expected %b/%b at %0t",
                     tag, got[W], got[W-1:0], exp[W], exp[W-1:0], $time);
        end
    endtask

    // Reference: arithmetic written in terms of the operation, not the circuit.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
        logic [W:0] r;
        if (op == 1'b0) begin
            r = {1'b0, a} + {1'b0, b};
        end else begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input logic [W:0] exp);
        @(negedge clk);
        in1  = a;
        in2  = b;
        ctrl = op;
        exp_q.push_back(exp);
    endtask

    task automatic apply_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        apply(a, b, op, model(a, b, op));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            check("sb", {crry, sum}, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        in1    = 4'b1111;
        in2    = 4'b1111;
        ctrl   = 1'b0;

        // Reset held with live operands: outputs stay cleared.
        #1;
        check("rst_init", {crry, sum}, 5'b0_0000);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rst_hold", {crry, sum}, 5'b0_0000);
        end

        // Release: first edge captures 1111 + 1111.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(5'b1_1110);

        // Directed add / subtract.
        apply(4'b0011, 4'b0101, 1'b0, 5'b0_1000);
        apply(4'b1111, 4'b0001, 1'b0, 5'b1_0000);
        apply(4'b0101, 4'b0011, 1'b1, 5'b1_0010);
        apply(4'b0011, 4'b0101, 1'b1, 5'b0_1110);
        apply(4'b0000, 4'b0000, 1'b1, 5'b1_0000);

        // Back-to-back alternating operation.
        for (int i = 0; i < 6; i++) begin
            apply(4'b1000, 4'b1000, i[0], 5'b1_0000);
        end

        // Async reset between edges while sum = 1110.
        apply(4'b0011, 4'b0101, 1'b1, 5'b0_1110);
        @(posedge clk);
        #3;
        check("pre_async_rst", {crry, sum}, 5'b0_1110);
        in1   = 4'b1111;
        in2   = 4'b0001;
        ctrl  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst", {crry, sum}, 5'b0_0000);
        @(posedge clk);
        #1;
        check("async_rst_hold", {crry, sum}, 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(5'b1_0000);

        // Exhaustive sweep.
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    apply_model(a[W-1:0], b[W-1:0], op[0]);
                end
            end
        end

        // Random tail.
        for (int i = 0; i < 32; i++) begin
            apply_model(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_four_bit_add_sub

// File: doc/four_bit_add_sub.md
Name: four_bit_add_sub

Overview:
- Registered 4-bit adder/subtractor. ctrl selects in1+in2 or in1-in2.
- Result and carry are registered, so they appear one clock after the operands are sampled.
- General arithmetic leaf used by datapath blocks. A ripple-carry core is built from full-adder cells, and the output register sits behind the core.

Parameters:
- WIDTH, 4, operand/result width in bits. The test plan targets 4; any WIDTH >= 1 must work.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in1  input  WIDTH  operand A (unsigned or two's complement)
- in2  input  WIDTH  operand B
- ctrl  input  1  operation select: 0 = add, 1 = subtract (A - B)
- sum  output  WIDTH  registered result bits
- crry  output  1  registered carry-out of the MSB cell

Behaviour:
- Reset:
  - When rst_n = 0, sum = 0 and crry = 0 immediately, independent of clk.
  - Outputs hold these values while rst_n is low.
- Release: the first capture occurs on the first rising clk edge with rst_n = 1.
- Core (combinational):
  - b_eff[i] = in2[i] XOR ctrl
  - carry-in of bit 0 = ctrl
  - each bit i uses a full adder: s[i] = a^b^c, c[i+1] = a&b | c&(a^b)
  - {c_out, s} = in1 + b_eff + ctrl, computed exactly at WIDTH+1 bits.
- Add (ctrl=0):
  - sum = (in1+in2) mod 2^WIDTH
  - crry = 1 iff the unsigned sum >= 2^WIDTH
- Subtract (ctrl=1):
  - sum = (in1-in2) mod 2^WIDTH, two's complement
  - crry = 1 iff in1 >= in2 unsigned (no borrow); crry = 0 means a borrow occurred
  - in2 = 0 always gives crry = 1
- Latency and timing:
  - On each rising clk edge with rst_n = 1, sum <= s and crry <= c_out.
  - Latency is exactly 1 cycle, one new result per cycle. There is no handshake and no enable; the block computes every cycle.
- Operand changes: mid-cycle input changes have no effect until the next edge. Only the values present at the edge are captured.
- Reset mid-operation: asserting rst_n asynchronously clears both outputs and discards the in-flight result. Capture resumes at the first edge after deassertion.
- Signed overflow: no port. Callers derive it externally if needed.
- No X propagation from internal state, since all state is reset.

Decomposition:
- Shared package four_bit_add_sub_pkg:
  - constant DEFAULT_WIDTH = 4
  - constants OP_ADD = 1'b0 and OP_SUB = 1'b1 for ctrl encoding
- One sub-module, full_adder_cell:
  - inputs a, b, cin; outputs s, cout
  - instantiated WIDTH times in a generate loop forming the ripple chain
- The top level holds the XOR inversion stage, the carry chain and the output registers.

Test Plan:
- Reset: hold rst_n=0 with in1=1111, in2=1111, ctrl=0 and clock several times -> sum=0000, crry=0 throughout. Deassert, then after 1 edge -> sum=1110, crry=1.
- Add: in1=0011, in2=0101, ctrl=0 -> next cycle sum=1000, crry=0. in1=1111, in2=0001 -> sum=0000, crry=1.
- Subtract:
  - in1=0101, in2=0011, ctrl=1 -> sum=0010, crry=1
  - in1=0011, in2=0101 -> sum=1110, crry=0
  - in1=0000, in2=0000 -> sum=0000, crry=1
- Back-to-back: alternate ctrl 0/1 each cycle with in1=1000, in2=1000 -> sum/crry sequence 0000/1, 0000/1, each appearing exactly one cycle after its operands.
- Async reset mid-stream: assert rst_n between edges while sum=1110 -> outputs read 0 before the next clk edge. Resume after release.
- Exhaustive: all 16x16 operand pairs x both ctrl values (512 vectors), each checked against the reference model {crry,sum} = in1 + (ctrl ? ~in2 : in2) + ctrl truncated to 5 bits.
